// File: rtl/timer_disp_pkg.sv
// timer_disp_pkg: shared constants, segment encodings and FSM state type for the BCD display back-end
package timer_disp_pkg;
  localparam int DIGITS = 6;
  localparam logic [19:0] MAX_VAL = 20'd999999;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DIGIT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/timer_bcd_disp_if.sv
// timer_bcd_disp_if: request/result bundle between the stopwatch side and the display converter
interface timer_bcd_disp_if #(
  parameter int W = 20,
  parameter int DIGITS = 6
);
  import timer_disp_pkg::*;
  logic [W-1:0] value_i;
  logic load;
  logic busy;
  logic done;
  logic ovf;
  logic [4*DIGITS-1:0] bcd;
  seg_t hex0, hex1, hex2, hex3, hex4, hex5;
  modport master (
    output value_i, load,
    input busy, done, ovf, bcd, hex0, hex1, hex2, hex3, hex4, hex5
  );
  modport slave (
    input value_i, load,
    output busy, done, ovf, bcd, hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/seg7_enc.sv
// seg7_enc: BCD nibble to active-low 7-segment pattern, with forced blanking
module seg7_enc
  import timer_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output seg_t       seg
);
  assign seg = (blank || nib > 4'd9) ? SEG_BLANK : SEG_DIGIT[nib];
endmodule

// File: rtl/timer_bcd_disp.sv
// timer_bcd_disp: sequential double-dabble conversion of the ms count onto six 7-segment digits
module timer_bcd_disp #(
  parameter int W = 20,
  parameter int DIGITS = 6,
  parameter bit BLANK_LZ = 1
) (
  input logic clk,
  input logic rst,
  timer_bcd_disp_if.slave bus
);
  import timer_disp_pkg::*;
  localparam int BW = 4 * DIGITS;
  state_t state;
  logic [BW-1:0] scratch, adj, shifted;
  logic [W-1:0] bin;
  logic [4:0] cnt;
  logic ovf_n, over;
  logic [DIGITS-1:0] blank;
  seg_t seg [DIGITS];
  assign over = bus.value_i > W'(MAX_VAL);
  assign shifted = {adj[BW-2:0], bin[W-1]};
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
    assign blank[i] = BLANK_LZ && i != 0 && bus.bcd[BW-1:4*i] == '0;
    seg7_enc u_seg (.nib(bus.bcd[4*i+:4]), .blank(blank[i]), .seg(seg[i]));
  end
  assign bus.hex0 = seg[0];
  assign bus.hex1 = seg[1];
  assign bus.hex2 = seg[2];
  assign bus.hex3 = seg[3];
  assign bus.hex4 = seg[4];
  assign bus.hex5 = seg[5];
  // Capture on load, run W shift-add-3 iterations, commit the final shifted scratch straight to bcd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf <= 1'b0;
      bus.bcd <= '0;
      scratch <= '0;
      bin <= '0;
      cnt <= '0;
      ovf_n <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.load) begin
          bin <= over ? W'(MAX_VAL) : bus.value_i;
          ovf_n <= over;
          scratch <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        scratch <= shifted;
        bin <= {bin[W-2:0], 1'b0};
        cnt <= cnt + 5'd1;
        if (cnt == 5'(W - 1)) begin
          bus.bcd <= shifted;
          bus.ovf <= ovf_n;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule
